mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the data port of the single-ported 16-bit unified memory between the CPU data path and a DMA/loader requester. It sits between the requesters and the memory's read/write/d_addr/d_bus interface. Each access is sequenced through a three-state machine. Grants rotate round-robin or follow fixed CPU priority, depending on the configuration macro. The instruction-fetch port is untouched.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset; asynchronous and active-high
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack  same as the cpu_* ports, for the DMA requester
- rdata  out  DW  read data, shared by both requesters; valid in the ack cycle and held until the next read completes
- mem_read  out  1  drives memory read enable (memory drives d_bus)
- mem_write  out  1  drives memory write enable
- mem_addr  out  AW  drives memory d_addr
- mem_wdata  out  DW  write data; top level drives d_bus = mem_write ? mem_wdata : 'z
- mem_rdata  in  DW  d_bus as seen by the arbiter

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: memory cycle.
  - ACK: pulse the winner's ack.
- IDLE with neither req high: stay in IDLE with all mem_* outputs at 0.
- IDLE with at least one req high: pick the winner and register it in grant.
  - Register mem_addr/mem_wdata from the winner's inputs.
  - Register mem_read = ~we and mem_write = we.
  - Go to ACCESS.
- ACCESS:
  - mem_* outputs stay constant for the whole state.
  - Memory writes at the end of this cycle.
  - On a read, capture rdata <= mem_rdata at the end of this cycle.
  - Go to ACK and clear mem_read/mem_write/mem_addr/mem_wdata to 0.
- ACK: assert the winner's ack for exactly one cycle, then go to IDLE.
- Requesters must drop req on the cycle after ack; req still high in IDLE is a new transaction.
- Arbitration is evaluated only in IDLE. A req raised during ACCESS/ACK waits.
- Both reqs in the same IDLE cycle: resolved by the policy in Configuration.
- last_grant records the winner of each arbitration; it is used only for round-robin.
- A write never updates rdata.
- mem_read and mem_write are never both 1, and are never 1 outside ACCESS.

## Timing
- Reset values:
  - state = IDLE, last_grant = DMA.
  - All outputs 0: cpu_ack, dma_ack, rdata, mem_read, mem_write, mem_addr, mem_wdata.
- Latency: req high at edge N (IDLE) gives ACCESS in cycle N+1, ack high in cycle N+2, and IDLE in cycle N+3.
- Throughput: one transaction per 3 cycles with back-to-back requests.
- Reset asserted mid-transaction:
  - Outputs clear immediately.
  - A write whose ACCESS edge coincides with or follows reset assertion is not performed.
  - No ack is issued; the requester must reissue.
- Address is passed through unchanged at AW bits; no wrap or offset arithmetic.

## Configuration
- MEM_ARB_RR_EN defined: round-robin.
  - On a simultaneous request, the port that is not last_grant wins.
  - A single requester always wins.
- MEM_ARB_RR_EN undefined: fixed priority, CPU always beats DMA.
  - last_grant is still maintained but ignored.
  - DMA may starve under continuous CPU traffic.

## Test plan
- Reset, then CPU write addr 0x0010 data 0xBEEF:
  - mem_write=1, mem_addr=0x0010, mem_wdata=0xBEEF in cycle N+1.
  - cpu_ack pulse in N+2.
  - A subsequent CPU read of 0x0010 gives rdata=0xBEEF with cpu_ack.
- DMA read of 0x0001 with memory preloaded to 0xAAAA: dma_ack in cycle N+2 with rdata=0xAAAA; cpu_ack stays 0.
- Both reqs high continuously for 4 transactions:
  - With MEM_ARB_RR_EN, grant order is CPU, DMA, CPU, DMA.
  - Without it, grant order is CPU, CPU, CPU, CPU.
- Reset asserted during ACCESS of a CPU write to 0x0020 (prior content 0x1234):
  - All outputs 0 immediately.
  - Memory still holds 0x1234; no ack.
  - State is IDLE after reset release.
- DMA req raised during CPU's ACCESS cycle: DMA is serviced starting at the next IDLE, with dma_ack exactly 3 cycles after the CPU ack.
- Across all scenarios, a checker asserts:
  - mem_read and mem_write are never both 1.
  - Each ack is exactly one cycle wide.
  - Acks are never simultaneous.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshake and memory data-port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, dma_ack, rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, dma_ack, rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter for the unified memory data port; MEM_ARB_RR_EN selects round-robin
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  logic [1:0]    state;
  // Winner of the most recent arbitration; also the owner of the access in flight.
  logic          last_grant;
  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Choose the winner among the current requesters and mux its request fields
  always_comb begin
    win = GRANT_CPU;
`ifdef MEM_ARB_RR_EN
    if (bus.cpu_req && bus.dma_req) begin
      win = ~last_grant;
    end else if (bus.dma_req) begin
      win = GRANT_DMA;
    end
`else
    if (!bus.cpu_req && bus.dma_req) begin
      win = GRANT_DMA;
    end
`endif
    win_we    = (win == GRANT_DMA) ? bus.dma_we    : bus.cpu_we;
    win_addr  = (win == GRANT_DMA) ? bus.dma_addr  : bus.cpu_addr;
    win_wdata = (win == GRANT_DMA) ? bus.dma_wdata : bus.cpu_wdata;
  end

  // Sequence each access IDLE -> ACCESS -> ACK, driving memory controls only in ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_grant    <= GRANT_DMA;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.rdata     <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            last_grant    <= win;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            bus.mem_read  <= ~win_we;
            bus.mem_write <= win_we;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Memory completes the write at this edge; reads are sampled here.
          if (bus.mem_read) begin
            bus.rdata <= bus.mem_rdata;
          end
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          bus.cpu_ack   <= (last_grant == GRANT_CPU);
          bus.dma_ack   <= (last_grant == GRANT_DMA);
          state         <= ST_ACK;
        end
        ST_ACK: begin
          bus.cpu_ack <= 1'b0;
          bus.dma_ack <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // memory model plus preload path
  logic [15:0] mem [0:65535];
  logic        mem_init = 1'b0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0;
      mem_init <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  // reference model state
  logic [15:0] ref_mem [0:65535];
  logic        ref_last;
  logic [15:0] ref_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pick_first(input logic c, input logic d);
    if (c && d) begin
`ifdef MEM_ARB_RR_EN
      return ~ref_last;
`else
      return 1'b0;
`endif
    end
    return (d && !c) ? 1'b1 : 1'b0;
  endfunction

  // protocol invariants
  logic prev_cack = 1'b0;
  logic prev_dack = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check("rw_exclusive", {31'd0, bus.mem_read && bus.mem_write}, 0);
      check("ack_exclusive", {31'd0, bus.cpu_ack && bus.dma_ack}, 0);
      if (prev_cack) check("cpu_ack_width", {31'd0, bus.cpu_ack}, 0);
      if (prev_dack) check("dma_ack_width", {31'd0, bus.dma_ack}, 0);
    end
    prev_cack = bus.cpu_ack;
    prev_dack = bus.dma_ack;
  end

  task automatic model_reset();
    ref_last  = 1'b1;
    ref_rdata = 16'h0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_round(input logic cen, input logic den, input int dma_delay,
                          input op_t cop, input op_t dop);
    int   got = 0;
    int   nexp;
    logic exp_first;
    logic port;
    logic cdone = 1'b0;
    logic ddone = 1'b0;
    logic p_rd = 1'b0, p_wr = 1'b0;
    logic [15:0] p_addr = '0, p_wdata = '0;
    op_t  op;
    nexp = int'(cen) + int'(den);
    exp_first = pick_first(cen, den && dma_delay == 0);
    @(posedge clk); #1;
    bus.cpu_req = cen; bus.cpu_we = cop.we; bus.cpu_addr = cop.addr; bus.cpu_wdata = cop.wdata;
    bus.dma_req = den && (dma_delay == 0);
    bus.dma_we = dop.we; bus.dma_addr = dop.addr; bus.dma_wdata = dop.wdata;
    for (int i = 1; i <= 12 && got < nexp; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.dma_ack) begin
        port = bus.dma_ack;
        check("ack_port", {31'd0, port}, {31'd0, (got == 0) ? exp_first : ~exp_first});
        check("ack_cycle", i, (got == 0) ? 3 : 6);
        op = port ? dop : cop;
        check("acc_addr", {16'd0, p_addr}, {16'd0, op.addr});
        check("acc_wdata", {16'd0, p_wdata}, {16'd0, op.wdata});
        check("acc_rdwr", {30'd0, p_rd, p_wr}, {30'd0, ~op.we, op.we});
        check("ack_mem_idle", {bus.mem_read, bus.mem_write, 14'd0, bus.mem_addr | bus.mem_wdata}, 0);
        if (op.we) ref_mem[op.addr] = op.wdata;
        else ref_rdata = ref_mem[op.addr];
        check("rdata", {16'd0, bus.rdata}, {16'd0, ref_rdata});
        ref_last = port;
        if (port) ddone = 1'b1; else cdone = 1'b1;
        got++;
      end
      p_rd = bus.mem_read; p_wr = bus.mem_write; p_addr = bus.mem_addr; p_wdata = bus.mem_wdata;
      if (den && dma_delay != 0 && i == dma_delay) begin
        #1 bus.dma_req = 1'b1;
      end
      @(posedge clk); #1;
      if (cdone) bus.cpu_req = 1'b0;
      if (ddone) bus.dma_req = 1'b0;
    end
    check("ack_count", got, nexp);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    if (cen && cop.we) check("mem_cpu_wr", {16'd0, mem[cop.addr]}, {16'd0, ref_mem[cop.addr]});
    if (den && dop.we) check("mem_dma_wr", {16'd0, mem[dop.addr]}, {16'd0, ref_mem[dop.addr]});
  endtask

  task automatic both_hold(input logic [15:0] ca, input logic [15:0] da);
    int   got = 0;
    int   last_i = 0;
    logic port;
    logic exp_port;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ca;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = da;
    for (int i = 1; i <= 16 && got < 4; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.dma_ack) begin
        port = bus.dma_ack;
        exp_port = pick_first(1'b1, 1'b1);
        check("hold_grant", {31'd0, port}, {31'd0, exp_port});
        check("hold_spacing", i - last_i, 3);
        ref_rdata = ref_mem[port ? da : ca];
        check("hold_rdata", {16'd0, bus.rdata}, {16'd0, ref_rdata});
        ref_last = port;
        last_i = i;
        got++;
      end
      @(posedge clk); #1;
      if (got == 4) begin
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
      end
    end
    check("hold_count", got, 4);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
  endtask

  task automatic reset_mid_write();
    logic seen_ack = 1'b0;
    preload(16'h0020, 16'h1234);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h5678;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_write", {31'd0, bus.mem_write}, 1);
    #1 rst = 1'b1;
    bus.cpu_req = 1'b0;
    model_reset();
    #1;
    check("rst_ctl", {28'd0, bus.cpu_ack, bus.dma_ack, bus.mem_read, bus.mem_write}, 0);
    check("rst_rdata", {16'd0, bus.rdata}, 0);
    check("rst_addr", {16'd0, bus.mem_addr}, 0);
    check("rst_wdata", {16'd0, bus.mem_wdata}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.dma_ack) seen_ack = 1'b1;
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.dma_ack) seen_ack = 1'b1;
    end
    check("rst_no_ack", {31'd0, seen_ack}, 0);
    check("rst_mem_kept", {16'd0, mem[16'h0020]}, 32'h1234);
  endtask

  initial begin
    op_t c, d;
    int  delays [5] = '{0, 0, 2, 3, 4};
    logic ce, de;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {28'd0, bus.cpu_ack, bus.dma_ack, bus.mem_read, bus.mem_write}, 0);
    check("reset_bus", {bus.mem_addr, bus.mem_wdata}, 0);
    check("reset_rdata", {16'd0, bus.rdata}, 0);
    rst = 1'b0;

    c = '{we: 1'b1, addr: 16'h0010, wdata: 16'hBEEF};
    do_round(1'b1, 1'b0, 0, c, c);
    c = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000};
    do_round(1'b1, 1'b0, 0, c, c);

    preload(16'h0001, 16'hAAAA);
    d = '{we: 1'b0, addr: 16'h0001, wdata: 16'h0000};
    do_round(1'b0, 1'b1, 0, c, d);

    apply_reset();
    both_hold(16'h0010, 16'h0001);

    reset_mid_write();
    d = '{we: 1'b0, addr: 16'h0020, wdata: 16'h0000};
    do_round(1'b0, 1'b1, 0, c, d);

    c = '{we: 1'b1, addr: 16'h0030, wdata: 16'hC0DE};
    d = '{we: 1'b0, addr: 16'h0030, wdata: 16'h0000};
    do_round(1'b1, 1'b1, 2, c, d);

    for (int r = 0; r < 60; r++) begin
      ce = 1'($urandom_range(0, 1));
      de = ce ? 1'($urandom_range(0, 1)) : 1'b1;
      c = '{we: 1'($urandom_range(0, 1)), addr: 16'($urandom_range(0, 15)), wdata: 16'($urandom)};
      d = '{we: 1'($urandom_range(0, 1)), addr: 16'($urandom_range(0, 15)), wdata: 16'($urandom)};
      do_round(ce, de, ce ? delays[$urandom_range(0, 4)] : 0, c, d);
    end

    both_hold(16'h0003, 16'h0007);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
